// File: rtl/sprite_spawn_scheduler.sv
// sprite_spawn_scheduler
// Frame-rate scheduler that launches one sprite at a time into an idle lane.
// Each launch is a one-hot level held for exactly one frame. A cooldown gap
// separates launches, and a 16-bit Fibonacci LFSR gates how often sprites spawn.
// All state advances only on the internal frame tick, except for reset.

module sprite_spawn_scheduler #(
  parameter logic [9:0]  MIN_GAP      = 10'd20,
  parameter logic [4:0]  SPAWN_THRESH = 5'd8,
  parameter logic [15:0] SEED         = 16'hACE1
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        frame_clk,
  input  logic        enable,
  input  logic [3:0]  lane_busy,
  output logic [3:0]  launch,
  output logic        active,
  output logic [1:0]  last_lane,
  output logic [15:0] spawn_count
);

  // An all-zero seed would lock the LFSR, so fall back to a known-good value
  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'hACE1 : SEED;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COOLDOWN = 2'd1,
    PICK     = 2'd2,
    ISSUE    = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        frame_q;
  logic        tick_q;
  logic [9:0]  gap_cnt_q, gap_cnt_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [3:0]  launch_q, launch_d;
  logic [1:0]  last_lane_q, last_lane_d;
  logic [15:0] spawn_count_q, spawn_count_d;
  logic        active_q, active_d;

  logic        roll_ok_s;
  logic        none_free_s;
  logic        lfsr_fb_s;
  logic [1:0]  cand_s;
  logic [1:0]  pick_lane_s;
  logic [1:0]  idx_s;
  logic        pick_found_s;

  // Roll, feedback and lane search all use the LFSR value from before this tick advances it
  assign roll_ok_s   = ({1'b0, lfsr_q[7:4]} < SPAWN_THRESH);
  assign none_free_s = &lane_busy;
  assign lfsr_fb_s   = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
  assign cand_s      = lfsr_q[1:0];

  // Frame-strobe rising-edge detector; produces a one-Clk tick
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      frame_q <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      frame_q <= frame_clk;
      tick_q  <= frame_clk & ~frame_q;
    end
  end

  // Rotating priority search: first idle lane starting at the random candidate
  always_comb begin
    pick_found_s = 1'b0;
    pick_lane_s  = 2'd0;
    idx_s        = 2'd0;
    for (int k = 0; k < 4; k++) begin
      idx_s = cand_s + 2'(k);
      if (!pick_found_s && !lane_busy[idx_s]) begin
        pick_found_s = 1'b1;
        pick_lane_s  = idx_s;
      end else begin
        pick_found_s = pick_found_s;
      end
    end
  end

  // State register and all datapath flops
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q       <= IDLE;
      gap_cnt_q     <= 10'd0;
      lfsr_q        <= SEED_EFF;
      launch_q      <= 4'b0000;
      last_lane_q   <= 2'd0;
      spawn_count_q <= 16'd0;
      active_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      gap_cnt_q     <= gap_cnt_d;
      lfsr_q        <= lfsr_d;
      launch_q      <= launch_d;
      last_lane_q   <= last_lane_d;
      spawn_count_q <= spawn_count_d;
      active_q      <= active_d;
    end
  end

  // Next-state logic, evaluated only on a frame tick
  always_comb begin
    state_d = state_q;
    if (tick_q) begin
      case (state_q)
        IDLE: begin
          if (enable) begin
            state_d = (MIN_GAP == 10'd0) ? PICK : COOLDOWN;
          end else begin
            state_d = IDLE;
          end
        end
        COOLDOWN: begin
          if (!enable) begin
            state_d = IDLE;
          end else if (gap_cnt_q <= 10'd1) begin
            state_d = PICK;
          end else begin
            state_d = COOLDOWN;
          end
        end
        PICK: begin
          if (!enable) begin
            state_d = IDLE;
          end else if (roll_ok_s && !none_free_s) begin
            state_d = ISSUE;
          end else begin
            state_d = PICK;
          end
        end
        ISSUE: begin
          // A committed launch always completes; enable only selects where we go next
          if (enable) begin
            state_d = (MIN_GAP == 10'd0) ? PICK : COOLDOWN;
          end else begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Output and datapath next values: launch level, gap counter, LFSR, counters
  always_comb begin
    gap_cnt_d     = gap_cnt_q;
    lfsr_d        = lfsr_q;
    launch_d      = launch_q;
    last_lane_d   = last_lane_q;
    spawn_count_d = spawn_count_q;
    if (tick_q) begin
      lfsr_d = {lfsr_q[14:0], lfsr_fb_s};
      case (state_q)
        IDLE: begin
          launch_d = 4'b0000;
          if (enable) begin
            gap_cnt_d = MIN_GAP;
          end else begin
            gap_cnt_d = gap_cnt_q;
          end
        end
        COOLDOWN: begin
          if (enable && (gap_cnt_q != 10'd0)) begin
            gap_cnt_d = gap_cnt_q - 10'd1;
          end else begin
            gap_cnt_d = gap_cnt_q;
          end
        end
        PICK: begin
          if (enable && roll_ok_s && pick_found_s) begin
            launch_d    = 4'b0001 << pick_lane_s;
            last_lane_d = pick_lane_s;
          end else begin
            launch_d = 4'b0000;
          end
        end
        ISSUE: begin
          launch_d      = 4'b0000;
          spawn_count_d = spawn_count_q + 16'd1;
          if (enable) begin
            gap_cnt_d = MIN_GAP;
          end else begin
            gap_cnt_d = gap_cnt_q;
          end
        end
        default: launch_d = 4'b0000;
      endcase
    end else begin
      lfsr_d = lfsr_q;
    end
  end

  // active tracks the state being entered so it lines up with the state register
  always_comb begin
    active_d = (state_d != IDLE);
  end

  assign launch      = launch_q;
  assign active      = active_q;
  assign last_lane   = last_lane_q;
  assign spawn_count = spawn_count_q;

endmodule
